gen_sine_osc: RTL and testbench
===============================

# gen_sine_osc

Parametrised recursive sine oscillator. It generates a sampled sinusoid with a two-register coupled (magic-circle) recurrence and needs no ROM. Frequency, amplitude, sample rate and output coding are set at run time and latched by a start command. It feeds the function-generator output mux / DAC path; a one-cycle strobe and a period marker are provided for downstream sample and scope logic.

## Interface
Parameters:
- DATA_W, 16: width of the signed sine/cosine state registers.
- OUT_W, 8: output sample width; must be ≤ DATA_W.
- DIV_W, 8: width of the sample-rate divider.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse; latches shift_k, amp, div, offset_bin and (re)starts the oscillator.
- stop  in  1  pulse; returns the block to idle.
- shift_k  in  $clog2(DATA_W)  frequency shift K; step is ≈2^-K rad per update.
- amp  in  DATA_W-1  unsigned initial cosine amplitude.
- div  in  DIV_W  an update occurs every div+1 clocks.
- offset_bin  in  1  1 selects offset-binary output; 0 selects two's-complement output.
- out  out  OUT_W  current sample.
- upd  out  1  one-cycle strobe marking a new sample on out.
- period  out  1  one-cycle strobe at each positive zero crossing.
- busy  out  1  high while in RUN.

## Operation
States: IDLE and RUN.
- IDLE → RUN on start.
- RUN → IDLE on stop.
- RUN → RUN on start: restarts with the new configuration.
- If start and stop arrive in the same cycle, start wins.

Start cycle:
- Config registers take shift_k, amp, div, offset_bin.
- A shift_k of 0 is latched as 1.
- s ← 0, c ← amp (zero-extended), divider ← 0.

Tick:
- The divider counts 0..div_q while in RUN.
- tick is asserted when the count equals div_q; the counter then wraps to 0.
- div_q = 0 gives a tick every clock.

Update on tick, signed arithmetic, wrapping, `>>>` is an arithmetic shift:
- s_n = s + (c >>> K)
- c_n = c − (s_n >>> K)
- The new s is used in the cosine update; this is the property that keeps the orbit closed.

Output coding:
- out = s[DATA_W-1 : DATA_W-OUT_W].
- When offset_bin_q = 1, the MSB of out is inverted.

Period detection:
- period is asserted on an update where s < 0 and s_n ≥ 0.

Overflow:
- The amplitude contract is amp ≤ 0.45·2^(DATA_W-1). Above that the arithmetic wraps; the result is legal but not specified.

Stop:
- s ← 0, c ← 0, divider ← 0.
- The offset_bin_q register is retained.

## Timing
Reset values: state IDLE, s = 0, c = 0, divider = 0, all config registers = 0, out = 0, upd = 0, period = 0, busy = 0.

Reset applied mid-RUN behaves exactly like power-on reset, one clock later. It overrides start and stop.

Cycle latencies:
- busy rises on the clock after start is sampled.
- The first tick occurs div_q+1 clocks after the start edge.
- s, c, upd and period all register on the tick edge, so out, upd and period change together. out therefore has 1-clock latency from the tick.

Output while idle:
- out = 0, or 2^(OUT_W-1) if offset_bin_q = 1.
- upd = 0 and period = 0.

Inputs are sampled only on the start cycle. Changes to shift_k, amp, div or offset_bin during RUN have no effect until the next start.

## Configuration
- GEN_SINE_RESYNC_EN defined: on an update that raises period, the block writes s ← 0, c ← amp_q instead of s_n, c_n. This removes long-term phase and amplitude drift. period still pulses on that update.
- GEN_SINE_RESYNC_EN undefined: the recurrence runs free, with no reload.

## Structure
- Package gen_sine_pkg holds the state enum (ST_IDLE, ST_RUN) and the default DATA_W, OUT_W and DIV_W constants.
- Sub-module gen_sine_tick is the DIV_W-wide divider.
  - Inputs: clk, rst, clr, en, div.
  - Output: tick.
- All other logic is a single module.

## Test plan
All scenarios use the default parameters.
1. Basic update sequence: start with K = 5, amp = 16384, div = 0, offset_bin = 0.
   - Update 1: s = 512, c = 16368, out = 2.
   - Update 2: s = 1023, c = 16337, out = 3.
   - upd is high every clock.
2. Divider: div = 3.
   - upd pulses exactly every 4 clocks.
   - The first pulse is 4 clocks after the start edge.
   - out is stable between pulses.
3. Period: K = 5, amp = 16384, div = 0.
   - Successive period strobes are 199 to 203 upd pulses apart.
   - The peak of out is within 62..66.
   - With GEN_SINE_RESYNC_EN, s = 0 and c = 16384 on every period update.
4. Offset binary: offset_bin = 1.
   - In IDLE after stop, out = 128.
   - After update 1 of scenario 1, out = 130.
5. Command collisions:
   - start and stop in the same cycle: busy = 1, s restarts from 0.
   - start during RUN with K = 6: the state reloads immediately and period spacing is ~402 updates.
6. Reset mid-RUN: assert rst for 1 clock.
   - Next cycle: out = 0, busy = 0, upd = 0, period = 0.
   - No upd pulses until a new start.

Source files
------------

// File: rtl/gen_sine_pkg.sv
// rtl/gen_sine_pkg.sv - shared state encoding and default widths for the sine oscillator.
package gen_sine_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_OUT_W  = 8;
  localparam int DEF_DIV_W  = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/gen_sine_tick.sv
// rtl/gen_sine_tick.sv - sample-rate divider; tick fires once every div+1 enabled clocks.
module gen_sine_tick #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  assign tick = en && (cnt == div);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/gen_sine_osc.sv
// rtl/gen_sine_osc.sv - magic-circle recursive sine oscillator with run-time config.
// Optional GEN_SINE_RESYNC_EN reloads s/c at each positive zero crossing.
module gen_sine_osc
  import gen_sine_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int OUT_W  = DEF_OUT_W,
  parameter int DIV_W  = DEF_DIV_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      stop,
  input  logic [$clog2(DATA_W)-1:0] shift_k,
  input  logic [DATA_W-2:0]         amp,
  input  logic [DIV_W-1:0]          div,
  input  logic                      offset_bin,
  output logic [OUT_W-1:0]          out,
  output logic                      upd,
  output logic                      period,
  output logic                      busy
);

  localparam int K_W = $clog2(DATA_W);

  state_t state, state_nx;

  logic [K_W-1:0]           k_q;
  logic [DIV_W-1:0]         div_q;
  logic                     offset_bin_q;
  logic signed [DATA_W-1:0] s_q, c_q;
  logic signed [DATA_W-1:0] s_n, c_n;
  logic                     crossing;
  logic                     upd_q, period_q;
  logic                     tick;
  logic                     running;
`ifdef GEN_SINE_RESYNC_EN
  logic [DATA_W-2:0]        amp_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (start) begin
      state_nx = ST_RUN;
    end else if (stop) begin
      state_nx = ST_IDLE;
    end
  end

  assign running = (state == ST_RUN);
  assign busy    = running;

  gen_sine_tick #(
    .DIV_W (DIV_W)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (start | stop),
    .en   (running),
    .div  (div_q),
    .tick (tick)
  );

  // The cosine update must use the freshly computed sine to keep the orbit closed.
  always_comb begin
    s_n      = s_q + (c_q >>> k_q);
    c_n      = c_q - (s_n >>> k_q);
    crossing = s_q[DATA_W-1] & ~s_n[DATA_W-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k_q          <= '0;
      div_q        <= '0;
      offset_bin_q <= 1'b0;
      s_q          <= '0;
      c_q          <= '0;
      upd_q        <= 1'b0;
      period_q     <= 1'b0;
    end else if (start) begin
      k_q          <= (shift_k == '0) ? K_W'(1) : shift_k;
      div_q        <= div;
      offset_bin_q <= offset_bin;
      s_q          <= '0;
      c_q          <= {1'b0, amp};
      upd_q        <= 1'b0;
      period_q     <= 1'b0;
    end else if (stop) begin
      s_q      <= '0;
      c_q      <= '0;
      upd_q    <= 1'b0;
      period_q <= 1'b0;
    end else if (running && tick) begin
      upd_q    <= 1'b1;
      period_q <= crossing;
`ifdef GEN_SINE_RESYNC_EN
      if (crossing) begin
        s_q <= '0;
        c_q <= {1'b0, amp_q};
      end else begin
        s_q <= s_n;
        c_q <= c_n;
      end
`else
      s_q <= s_n;
      c_q <= c_n;
`endif
    end else begin
      upd_q    <= 1'b0;
      period_q <= 1'b0;
    end
  end

`ifdef GEN_SINE_RESYNC_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      amp_q <= '0;
    end else if (start) begin
      amp_q <= amp;
    end
  end
`endif

  // Offset-binary is two's complement with the sign bit flipped.
  assign out    = s_q[DATA_W-1 -: OUT_W] ^ {offset_bin_q, {(OUT_W-1){1'b0}}};
  assign upd    = upd_q;
  assign period = period_q;

endmodule

// File: tb/tb_gen_sine_osc.sv
// tb/tb_gen_sine_osc.sv - self-checking bench for gen_sine_osc against a behavioural model.
module tb_gen_sine_osc;

  localparam int DATA_W = 16;
  localparam int OUT_W  = 8;
  localparam int DIV_W  = 8;
  localparam int K_W    = $clog2(DATA_W);

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              stop;
  logic [K_W-1:0]    shift_k;
  logic [DATA_W-2:0] amp;
  logic [DIV_W-1:0]  div;
  logic              offset_bin;
  logic [OUT_W-1:0]  out;
  logic              upd;
  logic              period;
  logic              busy;

  always #5 clk = ~clk;

  gen_sine_osc #(
    .DATA_W (DATA_W),
    .OUT_W  (OUT_W),
    .DIV_W  (DIV_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .shift_k    (shift_k),
    .amp        (amp),
    .div        (div),
    .offset_bin (offset_bin),
    .out        (out),
    .upd        (upd),
    .period     (period),
    .busy       (busy)
  );

  int n_chk = 0;
  int n_pass = 0;

  // Reference oscillator state, in plain integers.
  int ms, mc, mk, mamp, mdiv;
  int moff = 0;
  int edges, n_done, max_out;
  int per_idx[$];

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int wrap16(input int v);
    int w;
    w = v & 32'h0000_FFFF;
    if (w >= 32768) w = w - 65536;
    return w;
  endfunction

  function automatic int model_out();
    int b;
    b = (ms >>> 8) & 255;
    if (moff != 0) b = b ^ 128;
    return b;
  endfunction

  task automatic model_step(output int per);
    int sn, cn;
    sn  = wrap16(ms + (mc >>> mk));
    cn  = wrap16(mc - (sn >>> mk));
    per = (ms < 0 && sn >= 0) ? 1 : 0;
`ifdef GEN_SINE_RESYNC_EN
    if (per != 0) begin
      sn = 0;
      cn = mamp;
    end
`endif
    ms = sn;
    mc = cn;
  endtask

  task automatic do_start(input int k, input int a, input int d, input int ob, input int with_stop);
    shift_k    = K_W'(k);
    amp        = (DATA_W-1)'(a);
    div        = DIV_W'(d);
    offset_bin = ob[0];
    start      = 1'b1;
    stop       = with_stop[0];
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    ms = 0; mc = a; mk = (k == 0) ? 1 : k; mamp = a; mdiv = d; moff = ob;
    edges = 0; n_done = 0; max_out = -1000;
    per_idx.delete();
    check("busy_after_start", 32'(busy), 1);
    check("upd_after_start", 32'(upd), 0);
    check("s_after_start", 32'(dut.s_q), 0);
    check("out_after_start", 32'(out), model_out());
  endtask

  task automatic do_stop();
    stop = 1'b1;
    @(posedge clk);
    @(negedge clk);
    stop = 1'b0;
    ms = 0; mc = 0;
    check("busy_after_stop", 32'(busy), 0);
    check("out_idle", 32'(out), model_out());
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check("upd_idle", 32'(upd), 0);
      check("period_idle", 32'(period), 0);
    end
  endtask

  task automatic run_updates(input int n_upd);
    int limit, eu, per;
    limit = n_upd * (mdiv + 1) + 4;
    for (int cyc = 0; cyc < limit && n_done < n_upd; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      edges++;
      eu  = ((edges % (mdiv + 1)) == 0) ? 1 : 0;
      per = 0;
      check("upd", 32'(upd), eu);
      if (eu != 0) begin
        model_step(per);
        n_done++;
      end
      check("out", 32'(out), model_out());
      check("period", 32'(period), per);
      if (period === 1'b1) begin
        per_idx.push_back(n_done);
`ifdef GEN_SINE_RESYNC_EN
        check("resync_s", 32'(dut.s_q), 0);
        check("resync_c", 32'(dut.c_q), mamp);
`endif
      end
      if (moff == 0 && int'($signed(out)) > max_out) max_out = int'($signed(out));
    end
    check("run_budget", n_done, n_upd);
  endtask

  task automatic check_spacing(input string tag, input int lo, input int hi);
    int d;
    check({tag, "_two_strobes"}, (per_idx.size() >= 2) ? 1 : 0, 1);
    if (per_idx.size() >= 2) begin
      d = per_idx[1] - per_idx[0];
      if (d < lo || d > hi) $display("spacing %s = %0d", tag, d);
      check({tag, "_in_range"}, (d >= lo && d <= hi) ? 1 : 0, 1);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    shift_k = '0; amp = '0; div = '0; offset_bin = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out", 32'(out), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_upd", 32'(upd), 0);
    check("rst_period", 32'(period), 0);
    check("rst_s", 32'(dut.s_q), 0);
    check("rst_c", 32'(dut.c_q), 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic sequence, then long run for period spacing and peak.
    do_start(5, 16384, 0, 0, 0);
    run_updates(1);
    check("u1_s", 32'(dut.s_q), 512);
    check("u1_c", 32'(dut.c_q), 16368);
    check("u1_out", 32'(out), 2);
    run_updates(2);
    check("u2_s", 32'(dut.s_q), 1023);
    check("u2_c", 32'(dut.c_q), 16337);
    check("u2_out", 32'(out), 3);
    run_updates(650);
    check_spacing("k5_spacing", 199, 203);
    check("k5_peak", (max_out >= 62 && max_out <= 66) ? 1 : 0, 1);
    do_stop();
    check("idle_out_twos", 32'(out), 0);

    // Offset-binary coding.
    do_start(5, 16384, 0, 1, 0);
    run_updates(1);
    check("ob_u1_out", 32'(out), 130);
    do_stop();
    check("ob_idle_out", 32'(out), 128);

    // Divider: one update every 4 clocks, first 4 clocks after start.
    do_start(4, 10000, 3, 0, 0);
    run_updates(30);

    // start+stop collision while running: start wins.
    do_start(5, 12000, 0, 0, 1);
    run_updates(10);

    // Restart during RUN with K = 6; shift_k = 0 then also exercised.
    do_start(6, 16384, 0, 0, 0);
    run_updates(900);
    check_spacing("k6_spacing", 398, 406);
    do_start(0, 3000, 1, 0, 0);
    run_updates(20);

    // Reset in the middle of RUN.
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    moff = 0; ms = 0; mc = 0;
    check("midrst_out", 32'(out), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_upd", 32'(upd), 0);
    check("midrst_period", 32'(period), 0);
    repeat (20) begin
      @(posedge clk);
      @(negedge clk);
      check("midrst_no_upd", 32'(upd), 0);
    end

    // Randomised configurations within the amplitude contract.
    for (int it = 0; it < 8; it++) begin
      do_start(int'($urandom_range(3, 7)), int'($urandom_range(1, 14745)),
               int'($urandom_range(0, 4)), int'($urandom_range(0, 1)), 0);
      run_updates(80);
      if (it % 2 == 1) do_stop();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
